// File: rtl/gcd_multi_display.sv
// N-operand subtractive-Euclid GCD with quotient display and a visible countdown on a seven-segment bank.
// Define GCD_MULTI_BCD_DISPLAY_EN to show decimal digits instead of raw hex nibbles.
module gcd_multi_display #(
   parameter int N      = 3,
   parameter int W      = 8,
   parameter int DIGITS = 2,
   parameter int TICK   = 50_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [$clog2(N)-1:0]   select,
   input  logic                   add,
   input  logic                   next,
   input  logic [W-1:0]           data_in,
   output logic [7*DIGITS-1:0]    seg_out,
   output logic [W-1:0]           gcd_out,
   output logic                   busy,
   output logic                   done
);

   localparam int SW = $clog2(N);
   localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int DW = 4 * DIGITS;
   localparam logic [SW-1:0] LAST      = SW'(N - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

   typedef enum logic [2:0] {
      S_SETUP,
      S_COMPUTE,
      S_DIVIDE,
      S_SHOW,
      S_COUNTDOWN
   } state_t;

   state_t r_state, w_state_nxt;

   logic               r_add_prev, r_next_prev;
   logic               w_add_ev, w_next_ev;
   logic [W-1:0]       r_op [N];
   logic [W-1:0]       r_q  [N];
   logic [W-1:0]       r_a, r_b, r_rem, r_cnt, r_gcd;
   logic [SW-1:0]      r_k, r_i, w_sel, w_k_nxt, w_i_nxt;
   logic [TW-1:0]      r_tick;
   logic               r_first, r_done;
   logic [7*DIGITS-1:0] r_seg, w_seg;
   logic [W-1:0]       w_res, w_disp;
   logic               w_resolved, w_pair_last, w_div_done;
   logic [DW-1:0]      w_nibs;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_add_ev  = add & ~r_add_prev;
   assign w_next_ev = next & ~r_next_prev;
   assign w_k_nxt   = r_k + SW'(1);
   assign w_i_nxt   = r_i + SW'(1);
   assign gcd_out   = r_gcd;
   assign seg_out   = r_seg;

   always_comb begin
      w_sel = (int'(select) < N) ? select : '0;
   end

   // One Euclid step on the working pair; resolved when either side is zero or both match.
   always_comb begin
      w_resolved = 1'b1;
      w_res      = r_a;
      if (r_a == '0)
         w_res = r_b;
      else if (r_b == '0)
         w_res = r_a;
      else if (r_a == r_b)
         w_res = r_a;
      else
         w_resolved = 1'b0;
   end

   assign w_pair_last = ~r_first & w_resolved & (r_k == LAST);
   assign w_div_done  = (r_gcd == '0) || ((r_rem < r_gcd) && (r_i == LAST));

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_SETUP;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SETUP:     if (w_next_ev) w_state_nxt = S_COMPUTE;
         S_COMPUTE:   if (w_pair_last) w_state_nxt = S_DIVIDE;
         S_DIVIDE:    if (w_div_done) w_state_nxt = S_SHOW;
         S_SHOW:      if (w_next_ev) w_state_nxt = S_COUNTDOWN;
         S_COUNTDOWN: if (w_next_ev || (r_cnt == '0)) w_state_nxt = S_SETUP;
         default:     w_state_nxt = S_SETUP;
      endcase
   end

   always_comb begin
      busy   = (r_state == S_COMPUTE) || (r_state == S_DIVIDE);
      done   = r_done;
      w_disp = '0;
      case (r_state)
         S_SETUP:     w_disp = r_op[w_sel];
         S_COMPUTE:   w_disp = r_a;
         S_DIVIDE:    w_disp = r_gcd;
         S_SHOW:      w_disp = r_q[w_sel];
         S_COUNTDOWN: w_disp = r_cnt;
         default:     w_disp = '0;
      endcase
   end

`ifndef GCD_MULTI_BCD_DISPLAY_EN
   logic [DW+W-1:0] w_ext;
   assign w_ext = {{DW{1'b0}}, w_disp};
`endif

   // Truncated double-dabble: low BCD digits never depend on the dropped high ones.
   always_comb begin
      w_nibs = '0;
`ifdef GCD_MULTI_BCD_DISPLAY_EN
      for (int b = W - 1; b >= 0; b--) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (w_nibs[4*d +: 4] >= 4'd5)
               w_nibs[4*d +: 4] = w_nibs[4*d +: 4] + 4'd3;
         end
         w_nibs = {w_nibs[DW-2:0], w_disp[b]};
      end
`else
      w_nibs = w_ext[DW-1:0];
`endif
      w_seg = '0;
      for (int d = 0; d < DIGITS; d++)
         w_seg[7*d +: 7] = ~hex7(w_nibs[4*d +: 4]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_add_prev  <= 1'b0;
         r_next_prev <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_gcd       <= '0;
         r_k         <= '0;
         r_i         <= '0;
         r_tick      <= '0;
         r_first     <= 1'b1;
         r_done      <= 1'b0;
         r_seg       <= {DIGITS{~7'h3F}};
         for (int j = 0; j < N; j++) begin
            r_op[j] <= '0;
            r_q[j]  <= '0;
         end
      end else begin
         r_add_prev  <= add;
         r_next_prev <= next;
         r_done      <= (r_state == S_DIVIDE) && w_div_done;
         r_seg       <= w_seg;
         case (r_state)
            S_SETUP: begin
               r_first <= 1'b1;
               if (w_add_ev)
                  r_op[w_sel] <= r_op[w_sel] + data_in;
            end
            S_COMPUTE: begin
               if (r_first) begin
                  r_a     <= r_op[0];
                  r_b     <= r_op[1];
                  r_k     <= SW'(1);
                  r_first <= 1'b0;
               end else if (w_resolved) begin
                  r_a <= w_res;
                  if (r_k == LAST) begin
                     r_gcd <= w_res;
                     r_i   <= '0;
                     r_rem <= r_op[0];
                     for (int j = 0; j < N; j++)
                        r_q[j] <= '0;
                  end else begin
                     r_k <= w_k_nxt;
                     r_b <= r_op[w_k_nxt];
                  end
               end else if (r_a > r_b) begin
                  r_a <= r_a - r_b;
               end else begin
                  r_b <= r_b - r_a;
               end
            end
            S_DIVIDE: begin
               if (r_gcd != '0) begin
                  if (r_rem >= r_gcd) begin
                     r_rem    <= r_rem - r_gcd;
                     r_q[r_i] <= r_q[r_i] + W'(1);
                  end else if (r_i != LAST) begin
                     r_i   <= w_i_nxt;
                     r_rem <= r_op[w_i_nxt];
                  end
               end
            end
            S_SHOW: begin
               if (w_next_ev) begin
                  r_cnt  <= r_gcd;
                  r_tick <= '0;
               end
            end
            S_COUNTDOWN: begin
               if (!w_next_ev && (r_cnt != '0)) begin
                  if (r_tick == TICK_LAST) begin
                     r_tick <= '0;
                     r_cnt  <= r_cnt - W'(1);
                  end else begin
                     r_tick <= r_tick + TW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_multi_display.sv
// Scoreboard bench for gcd_multi_display (N=3, W=8, DIGITS=2, TICK=4).
module tb_gcd_multi_display;

   localparam int K_SEG  = 0;
   localparam int K_GCD  = 1;
   localparam int K_BUSY = 2;
   localparam int K_DONE = 3;
   localparam int K_EVT  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        add = 1'b0;
   logic        next = 1'b0;
   logic [1:0]  select = 2'd0;
   logic [7:0]  data_in = 8'd0;
   logic [13:0] seg_out;
   logic [7:0]  gcd_out;
   logic        busy;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] q_dexp[$];
   int          q_kind[$];
   logic [31:0] q_val[$];
   string       q_name[$];
   logic        obs_stb = 1'b0;
   logic        ev_ok = 1'b0;

   gcd_multi_display #(.N(3), .W(8), .DIGITS(2), .TICK(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .select  (select),
      .add     (add),
      .next    (next),
      .data_in (data_in),
      .seg_out (seg_out),
      .gcd_out (gcd_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   function automatic logic [31:0] seg_of(input logic [7:0] v);
      logic [13:0] s;
      s = {~hex7(v[7:4]), ~hex7(v[3:0])};
      seg_of = 32'(s);
   endfunction

   // Monitor: result checks on done, observation checks when the stimulus strobes.
   initial begin
      logic [31:0] e_gcd, e_val, act;
      int          e_kind;
      string       e_name;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_tests++;
            if (q_dexp.size() == 0) begin
               n_fail++;
               $display("FAIL done_unexpected: got done with gcd_out=%0d, required no done", gcd_out);
            end else begin
               e_gcd = q_dexp.pop_front();
               if (32'(gcd_out) !== e_gcd) begin
                  n_fail++;
                  $display("FAIL gcd_at_done: got %0d, required %0d", gcd_out, e_gcd);
               end
            end
         end
         if (obs_stb) begin
            n_tests++;
            if (q_kind.size() == 0) begin
               n_fail++;
               $display("FAIL obs_queue: got empty queue, required an entry");
            end else begin
               e_kind = q_kind.pop_front();
               e_val  = q_val.pop_front();
               e_name = q_name.pop_front();
               case (e_kind)
                  K_SEG:   act = 32'(seg_out);
                  K_GCD:   act = 32'(gcd_out);
                  K_BUSY:  act = 32'(busy);
                  K_DONE:  act = 32'(done);
                  default: act = 32'(ev_ok);
               endcase
               if (act !== e_val) begin
                  n_fail++;
                  $display("FAIL %s: got 0x%0h, required 0x%0h", e_name, act, e_val);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int k, input logic [31:0] v, input string nm);
      q_kind.push_back(k);
      q_val.push_back(v);
      q_name.push_back(nm);
      obs_stb = 1'b1;
      step();
      obs_stb = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; add = 1'b0; next = 1'b0; select = 2'd0; data_in = 8'd0;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic press_add(input logic [1:0] s, input logic [7:0] v);
      select = s; data_in = v; add = 1'b1;
      step();
      add = 1'b0;
      step();
   endtask

   task automatic press_next();
      next = 1'b1;
      step();
      next = 1'b0;
      step();
   endtask

   task automatic wait_done(input int budget, input string nm);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      ev_ok = (done === 1'b1);
      chk(K_EVT, 1, nm);
   endtask

   task automatic check_q(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0] e[3];
      e[0] = e0; e[1] = e1; e[2] = e2;
      for (int s = 0; s < 3; s++) begin
         select = 2'(s);
         step();
         chk(K_SEG, seg_of(e[s]), $sformatf("q%0d_display", s));
      end
   endtask

   initial begin
      // Reset state
      step(); step();
      rst = 1'b0;
      step();
      chk(K_SEG,  seg_of(8'd0), "reset_seg");
      chk(K_GCD,  0, "reset_gcd");
      chk(K_BUSY, 0, "reset_busy");
      chk(K_DONE, 0, "reset_done");

      // Basic 12, 18, 30 -> 6; quotients 2, 3, 5
      press_add(2'd0, 8'd12);
      press_add(2'd1, 8'd18);
      press_add(2'd2, 8'd30);
      chk(K_SEG, seg_of(8'd30), "setup_op2");
      q_dexp.push_back(6);
      press_next();
      chk(K_BUSY, 1, "busy_compute");
      wait_done(300, "done_basic");
      check_q(8'd2, 8'd3, 8'd5);
      select = 2'd3;
      step();
      chk(K_SEG, seg_of(8'd2), "select_oob_is_op0");
      chk(K_DONE, 0, "done_single_pulse");
      chk(K_BUSY, 0, "busy_show");
      // Abort countdown from 6 after a few cycles
      select = 2'd2;
      press_next();
      step(); step();
      press_next();
      chk(K_SEG, seg_of(8'd30), "abort_to_setup");
      chk(K_GCD, 6, "gcd_retained");

      // Countdown from 3 with TICK=4
      do_reset();
      press_add(2'd0, 8'd3);
      press_add(2'd1, 8'd9);
      press_add(2'd2, 8'd6);
      q_dexp.push_back(3);
      press_next();
      wait_done(300, "done_cd");
      check_q(8'd1, 8'd3, 8'd2);
      select = 2'd1;
      step();
      next = 1'b1;
      step();
      next = 1'b0;
      step();
      for (int v = 3; v >= 1; v--)
         for (int i = 0; i < 4; i++)
            chk(K_SEG, seg_of(8'(v)), $sformatf("cd_val%0d_cyc%0d", v, i));
      chk(K_SEG, seg_of(8'd0), "cd_zero");
      chk(K_SEG, seg_of(8'd9), "cd_back_to_setup");

      // Add wrap and held button
      do_reset();
      press_add(2'd0, 8'd250);
      select = 2'd0; data_in = 8'd10; add = 1'b1;
      repeat (100) step();
      add = 1'b0;
      step();
      chk(K_SEG, seg_of(8'd4), "add_wrap_hold");

      // Zero operands 0, 0, 9
      do_reset();
      press_add(2'd2, 8'd9);
      q_dexp.push_back(9);
      press_next();
      wait_done(300, "done_009");
      check_q(8'd0, 8'd0, 8'd1);

      // All zero -> gcd 0, quick exit from countdown
      do_reset();
      q_dexp.push_back(0);
      press_next();
      wait_done(50, "done_000");
      check_q(8'd0, 8'd0, 8'd0);
      press_next();
      press_add(2'd0, 8'd5);
      chk(K_SEG, seg_of(8'd5), "zero_cd_exit");

      // Simultaneous add and next: op0 = 6 included
      do_reset();
      press_add(2'd1, 8'd9);
      press_add(2'd2, 8'd3);
      q_dexp.push_back(3);
      select = 2'd0; data_in = 8'd6; add = 1'b1; next = 1'b1;
      step();
      add = 1'b0; next = 1'b0;
      step();
      wait_done(300, "done_simul");
      check_q(8'd2, 8'd3, 8'd1);

      // Leave SHOW, edit to 200, 2, 1 via wrap, reset mid-COMPUTE
      press_next();
      press_next();
      press_add(2'd0, 8'd194);
      press_add(2'd1, 8'd249);
      press_add(2'd2, 8'd254);
      select = 2'd0;
      step();
      chk(K_SEG, seg_of(8'd200), "edit_op0");
      press_next();
      step();
      chk(K_BUSY, 1, "busy_pre_rst");
      rst = 1'b1;
      step();
      chk(K_BUSY, 0, "busy_after_rst");
      chk(K_GCD, 0, "gcd_after_rst");
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         select = 2'(s);
         step();
         chk(K_SEG, seg_of(8'd0), $sformatf("op%0d_after_rst", s));
      end
      repeat (150) step();
      press_add(2'd0, 8'd7);
      chk(K_SEG, seg_of(8'd7), "setup_after_rst");

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
